// File: rtl/bf2_pipe.sv
// bf2_pipe: pipelined radix-2 DIT butterfly, X0 = A + W*B, X1 = A - W*B, 3-cycle latency from the B beat
module bf2_pipe #(
  parameter int bit_width = 29,
  parameter int TW_W      = 16,
  parameter int SIZE      = 4,
  parameter int SCALE     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [bit_width-1:0] in_re,
  input  logic [bit_width-1:0] in_im,
  input  logic [TW_W-1:0]      tw_re,
  input  logic [TW_W-1:0]      tw_im,
  input  logic [SIZE-1:0]      adr_ptr1_i,
  input  logic [SIZE-1:0]      adr_ptr2_i,
  output logic [bit_width-1:0] out_re0,
  output logic [bit_width-1:0] out_im0,
  output logic [bit_width-1:0] out_re1,
  output logic [bit_width-1:0] out_im1,
  output logic [SIZE-1:0]      adr_ptr1,
  output logic [SIZE-1:0]      adr_ptr2,
  output logic                 en_back_mem,
  output logic                 ovf
);
  localparam int PW = bit_width + TW_W;
  localparam int IW = bit_width + 2;
  localparam logic signed [IW-1:0] SMAX = {3'b000, {(bit_width-1){1'b1}}};
  localparam logic signed [IW-1:0] SMIN = {3'b111, {(bit_width-1){1'b0}}};
  localparam logic signed [PW-1:0] RND  = {{IW{1'b0}}, 1'b1, {(TW_W-3){1'b0}}};

  typedef enum logic {WAIT_A, WAIT_B} phase_t;
  phase_t phase, phase_nxt;
  logic a_beat, b_beat, v1, v2;
  logic [bit_width-1:0] a_re, a_im, a_re1, a_im1, a_re2, a_im2;
  logic [SIZE-1:0] a_adr, adr1_1, adr2_1, adr1_2, adr2_2;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir, pr_full, pi_full;
  logic signed [IW-1:0] pr2, pi2, s_re0, s_im0, s_re1, s_im1;
  logic [bit_width:0] f_re0, f_im0, f_re1, f_im1;

  // scale or clamp a bit_width+2 sum into bit_width; top bit reports out-of-range
  function automatic logic [bit_width:0] fit(input logic signed [IW-1:0] s);
    logic signed [IW-1:0] v;
    v = (SCALE != 0) ? (s >>> 1) : s;
    return {v > SMAX || v < SMIN,
            v > SMAX ? SMAX[bit_width-1:0] : v < SMIN ? SMIN[bit_width-1:0] : v[bit_width-1:0]};
  endfunction

  // next phase and beat qualifiers; flush overrides any valid beat
  always_comb begin
    a_beat    = in_valid && !flush && phase == WAIT_A;
    b_beat    = in_valid && !flush && phase == WAIT_B;
    phase_nxt = flush ? WAIT_A : in_valid ? (phase == WAIT_A ? WAIT_B : WAIT_A) : phase;
  end

  // input phase register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= WAIT_A;
    else        phase <= phase_nxt;

  // hold the top sample and its address until the matching bottom sample arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      a_re  <= '0;
      a_im  <= '0;
      a_adr <= '0;
    end else if (a_beat) begin
      a_re  <= in_re;
      a_im  <= in_im;
      a_adr <= adr_ptr1_i;
    end
  end

  // stage 1: four partial products; A and addresses travel alongside so a new A can be latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      {p_rr, p_ii, p_ri, p_ir} <= '0;
      {a_re1, a_im1, adr1_1, adr2_1} <= '0;
    end else begin
      v1 <= b_beat;
      if (b_beat) begin
        p_rr   <= PW'($signed(in_re)) * PW'($signed(tw_re));
        p_ii   <= PW'($signed(in_im)) * PW'($signed(tw_im));
        p_ri   <= PW'($signed(in_re)) * PW'($signed(tw_im));
        p_ir   <= PW'($signed(in_im)) * PW'($signed(tw_re));
        a_re1  <= a_re;
        a_im1  <= a_im;
        adr1_1 <= a_adr;
        adr2_1 <= adr_ptr2_i;
      end
    end
  end

  // rounded complex product before the shift back to sample scale
  always_comb begin
    pr_full = p_rr - p_ii + RND;
    pi_full = p_ri + p_ir + RND;
  end

  // stage 2: W*B shifted down to bit_width+2 bits, no saturation yet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      {pr2, pi2, a_re2, a_im2, adr1_2, adr2_2} <= '0;
    end else begin
      v2 <= v1 && !flush;
      if (v1) begin
        pr2    <= pr_full[TW_W-2 +: IW];
        pi2    <= pi_full[TW_W-2 +: IW];
        a_re2  <= a_re1;
        a_im2  <= a_im1;
        adr1_2 <= adr1_1;
        adr2_2 <= adr2_1;
      end
    end
  end

  // butterfly sums at full width, then fitted to the output width
  always_comb begin
    s_re0 = IW'($signed(a_re2)) + pr2;
    s_im0 = IW'($signed(a_im2)) + pi2;
    s_re1 = IW'($signed(a_re2)) - pr2;
    s_im1 = IW'($signed(a_im2)) - pi2;
    f_re0 = fit(s_re0);
    f_im0 = fit(s_im0);
    f_re1 = fit(s_re1);
    f_im1 = fit(s_im1);
  end

  // stage 3: result registers, write-back pulse and sticky overflow; data survives a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_back_mem <= 1'b0;
      ovf         <= 1'b0;
      {out_re0, out_im0, out_re1, out_im1, adr_ptr1, adr_ptr2} <= '0;
    end else begin
      en_back_mem <= v2 && !flush;
      if (flush) ovf <= 1'b0;
      else if (v2) begin
        out_re0  <= f_re0[bit_width-1:0];
        out_im0  <= f_im0[bit_width-1:0];
        out_re1  <= f_re1[bit_width-1:0];
        out_im1  <= f_im1[bit_width-1:0];
        adr_ptr1 <= adr1_2;
        adr_ptr2 <= adr2_2;
        ovf      <= ovf | f_re0[bit_width] | f_im0[bit_width] | f_re1[bit_width] | f_im1[bit_width];
      end
    end
  end
endmodule

// File: tb/tb_bf2_pipe.sv
// tb_bf2_pipe: randomized and directed checks of bf2_pipe against an integer butterfly model
module tb_bf2_pipe;
  localparam int BW = 29;
  localparam int TW = 16;
  localparam int SZ = 4;
  localparam int SC = 0;
  localparam longint MAXV = (longint'(1) << (BW-1)) - 1;
  localparam longint MINV = -(longint'(1) << (BW-1));

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0;
  logic [BW-1:0] in_re = '0, in_im = '0;
  logic [TW-1:0] tw_re = '0, tw_im = '0;
  logic [SZ-1:0] adr_ptr1_i = '0, adr_ptr2_i = '0;
  logic [BW-1:0] out_re0, out_im0, out_re1, out_im1;
  logic [SZ-1:0] adr_ptr1, adr_ptr2;
  logic en_back_mem, ovf;
  int cyc = 0, errors = 0, checks = 0;

  bf2_pipe #(.bit_width(BW), .TW_W(TW), .SIZE(SZ), .SCALE(SC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_re(in_re), .in_im(in_im), .tw_re(tw_re), .tw_im(tw_im),
    .adr_ptr1_i(adr_ptr1_i), .adr_ptr2_i(adr_ptr2_i),
    .out_re0(out_re0), .out_im0(out_im0), .out_re1(out_re1), .out_im1(out_im1),
    .adr_ptr1(adr_ptr1), .adr_ptr2(adr_ptr2), .en_back_mem(en_back_mem), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint fitv(input longint s);
    longint v = SC != 0 ? (s >>> 1) : s;
    return v > MAXV ? MAXV : v < MINV ? MINV : v;
  endfunction

  function automatic bit oorv(input longint s);
    longint v = SC != 0 ? (s >>> 1) : s;
    return v > MAXV || v < MINV;
  endfunction

  function automatic void golden(input longint ar, ai, br, bi, wr, wi,
                                 output longint x0r, x0i, x1r, x1i, output bit o);
    longint pr, pi, h;
    h  = longint'(1) << (TW-3);
    pr = (br*wr - bi*wi + h) >>> (TW-2);
    pi = (br*wi + bi*wr + h) >>> (TW-2);
    x0r = fitv(ar + pr);
    x0i = fitv(ai + pi);
    x1r = fitv(ar - pr);
    x1i = fitv(ai - pi);
    o = oorv(ar + pr) | oorv(ai + pi) | oorv(ar - pr) | oorv(ai - pi);
  endfunction

  task automatic drive(input logic v, input int re, im, wr, wi, a1, a2, input logic fl);
    @(negedge clk);
    in_valid = v; flush = fl;
    in_re = BW'(re); in_im = BW'(im);
    tw_re = TW'(wr); tw_im = TW'(wi);
    adr_ptr1_i = SZ'(a1); adr_ptr2_i = SZ'(a2);
  endtask

  task automatic pair(input int ar, ai, br, bi, wr, wi, a1, a2);
    drive(1, ar, ai, 0, 0, a1, 0, 0);
    drive(1, br, bi, wr, wi, 0, a2, 0);
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 0; flush = 0;
      if (en_back_mem) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_re0, out_im0, out_re1, out_im1, adr_ptr1, adr_ptr2} !== '0) begin
      errors++; $display("FAIL reset_outputs: got re0=%0h im0=%0h re1=%0h im1=%0h a1=%0d a2=%0d exp all 0",
                         out_re0, out_im0, out_re1, out_im1, adr_ptr1, adr_ptr2);
    end
    checks++;
    if (en_back_mem !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got en=%b ovf=%b exp 0 0", en_back_mem, ovf);
    end
    rst_n = 1;
  endtask

  task automatic test_basic;
    int lat;
    pair(100, 0, 50, 0, 16384, 0, 5, 9);
    wait_pulse(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d exp 3", lat); end
    checks++;
    if (out_re0 !== BW'(150) || out_im0 !== '0 || out_re1 !== BW'(50) || out_im1 !== '0) begin
      errors++; $display("FAIL basic_data: got (%0d,%0d) (%0d,%0d) exp (150,0) (50,0)",
                         $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1));
    end
    checks++;
    if (adr_ptr1 !== 4'd5 || adr_ptr2 !== 4'd9) begin
      errors++; $display("FAIL basic_adr: got %0d %0d exp 5 9", adr_ptr1, adr_ptr2);
    end
    @(negedge clk);
    checks++;
    if (en_back_mem !== 1'b0 || adr_ptr2 !== 4'd9 || out_re0 !== BW'(150)) begin
      errors++; $display("FAIL basic_hold: got en=%b a2=%0d re0=%0d exp 0 9 150",
                         en_back_mem, adr_ptr2, $signed(out_re0));
    end
  endtask

  task automatic test_twiddle;
    int lat;
    pair(0, 0, 1000, 0, 0, -16384, 1, 2);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== '0 || out_im0 !== BW'(-1000) || out_re1 !== '0 || out_im1 !== BW'(1000)) begin
      errors++; $display("FAIL neg_j: got lat=%0d (%0d,%0d) (%0d,%0d) exp lat=3 (0,-1000) (0,1000)", lat,
                         $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1));
    end
    pair(0, 0, 3, 0, 8192, 0, 3, 4);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'(2) || out_re1 !== BW'(-2)) begin
      errors++; $display("FAIL rounding: got lat=%0d re0=%0d re1=%0d exp 3 2 -2", lat,
                         $signed(out_re0), $signed(out_re1));
    end
  endtask

  task automatic test_saturation;
    int lat;
    pair((1<<28)-1, 0, (1<<28)-1, 0, 16384, 0, 6, 7);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'((1<<28)-1) || out_re1 !== '0 || ovf !== 1'b1) begin
      errors++; $display("FAIL sat_pos: got lat=%0d re0=%0d re1=%0d ovf=%b exp 3 %0d 0 1", lat,
                         $signed(out_re0), $signed(out_re1), ovf, (1<<28)-1);
    end
    pair(-(1<<28), 0, -(1<<28), 0, 16384, 0, 0, 1);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'(-(1<<28)) || out_re1 !== '0) begin
      errors++; $display("FAIL sat_neg: got lat=%0d re0=%0d re1=%0d exp 3 %0d 0", lat,
                         $signed(out_re0), $signed(out_re1), -(1<<28));
    end
    pair(10, 0, 20, 0, 16384, 0, 2, 3);
    wait_pulse(lat);
    checks++;
    if (ovf !== 1'b1 || out_re0 !== BW'(30)) begin
      errors++; $display("FAIL sat_sticky: got ovf=%b re0=%0d exp 1 30", ovf, $signed(out_re0));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ovf !== 1'b0 || out_re0 !== BW'(30)) begin
      errors++; $display("FAIL sat_flush: got ovf=%b re0=%0d exp 0 30", ovf, $signed(out_re0));
    end
  endtask

  task automatic test_back_to_back;
    int ar[8], ai[8], br[8], bi[8], wr[8], wi[8], bc[8];
    int idx = 0;
    for (int k = 0; k < 8; k++) begin
      ar[k] = int'($urandom_range(0, 1<<28)) - (1<<27);
      ai[k] = int'($urandom_range(0, 1<<28)) - (1<<27);
      br[k] = int'($urandom_range(0, 1<<28)) - (1<<27);
      bi[k] = int'($urandom_range(0, 1<<28)) - (1<<27);
      wr[k] = int'($urandom_range(0, 32768)) - 16384;
      wi[k] = int'($urandom_range(0, 32768)) - 16384;
    end
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          drive(1, ar[k], ai[k], 0, 0, 2*k, 0, 0);
          drive(1, br[k], bi[k], wr[k], wi[k], 0, 2*k+1, 0);
          bc[k] = cyc;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
      begin
        for (int i = 0; i < 30 && idx < 8; i++) begin
          @(negedge clk);
          if (en_back_mem) begin
            longint e0r, e0i, e1r, e1i;
            bit o;
            golden(ar[idx], ai[idx], br[idx], bi[idx], wr[idx], wi[idx], e0r, e0i, e1r, e1i, o);
            checks++;
            if (cyc != bc[idx] + 3) begin
              errors++; $display("FAIL b2b_timing[%0d]: got cycle %0d exp %0d", idx, cyc, bc[idx] + 3);
            end
            checks++;
            if (out_re0 !== BW'(e0r) || out_im0 !== BW'(e0i) || out_re1 !== BW'(e1r) || out_im1 !== BW'(e1i)) begin
              errors++; $display("FAIL b2b_data[%0d]: got (%0d,%0d) (%0d,%0d) exp (%0d,%0d) (%0d,%0d)", idx,
                                 $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1),
                                 e0r, e0i, e1r, e1i);
            end
            checks++;
            if (adr_ptr1 !== SZ'(2*idx) || adr_ptr2 !== SZ'(2*idx+1)) begin
              errors++; $display("FAIL b2b_adr[%0d]: got %0d %0d exp %0d %0d", idx, adr_ptr1, adr_ptr2,
                                 2*idx, 2*idx+1);
            end
            idx++;
          end
        end
      end
    join
    checks++;
    if (idx != 8) begin errors++; $display("FAIL b2b_count: got %0d pulses exp 8", idx); end
  endtask

  task automatic test_gap_flush;
    int lat;
    drive(1, -700, 300, 0, 0, 11, 0, 0);
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 400, -200, 0, 16384, 0, 12, 0);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'(-500) || out_im0 !== BW'(700) || out_re1 !== BW'(-900) ||
        out_im1 !== BW'(-100) || adr_ptr1 !== 4'd11 || adr_ptr2 !== 4'd12) begin
      errors++; $display("FAIL gap: got lat=%0d (%0d,%0d) (%0d,%0d) a=%0d,%0d exp 3 (-500,700) (-900,-100) a=11,12",
                         lat, $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1),
                         adr_ptr1, adr_ptr2);
    end
    drive(1, 9999, 9999, 0, 0, 15, 0, 0);
    drive(1, 8888, 8888, 16384, 0, 0, 14, 1);
    pair(7, 1, 3, 2, 16384, 0, 8, 10);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'(10) || out_im0 !== BW'(3) || out_re1 !== BW'(4) || out_im1 !== BW'(-1) ||
        adr_ptr1 !== 4'd8 || adr_ptr2 !== 4'd10) begin
      errors++; $display("FAIL flush_fresh_pair: got lat=%0d (%0d,%0d) (%0d,%0d) a=%0d,%0d exp 3 (10,3) (4,-1) a=8,10",
                         lat, $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1),
                         adr_ptr1, adr_ptr2);
    end
    pair(50, 50, 50, 50, 16384, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    wait_pulse(lat);
    checks++;
    if (lat != -1 || out_re0 !== BW'(10)) begin
      errors++; $display("FAIL flush_inflight: got lat=%0d re0=%0d exp no pulse, re0=10", lat, $signed(out_re0));
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    pair(123, 45, 67, 89, 16384, 0, 13, 14);
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    checks++;
    if ({out_re0, out_im0, out_re1, out_im1, adr_ptr1, adr_ptr2, en_back_mem, ovf} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: got re0=%0h im0=%0h re1=%0h im1=%0h a1=%0d a2=%0d en=%b ovf=%b exp 0",
                         out_re0, out_im0, out_re1, out_im1, adr_ptr1, adr_ptr2, en_back_mem, ovf);
    end
    @(negedge clk);
    rst_n = 1;
    wait_pulse(lat);
    checks++;
    if (lat != -1) begin errors++; $display("FAIL reset_mid_nopulse: got pulse at %0d exp none", lat); end
    pair(1000, -1000, 500, 250, 16384, 0, 2, 6);
    wait_pulse(lat);
    checks++;
    if (lat != 3 || out_re0 !== BW'(1500) || out_im0 !== BW'(-750) || out_re1 !== BW'(500) ||
        out_im1 !== BW'(-1250) || adr_ptr1 !== 4'd2 || adr_ptr2 !== 4'd6) begin
      errors++; $display("FAIL reset_mid_recover: got lat=%0d (%0d,%0d) (%0d,%0d) a=%0d,%0d exp 3 (1500,-750) (500,-1250) a=2,6",
                         lat, $signed(out_re0), $signed(out_im0), $signed(out_re1), $signed(out_im1),
                         adr_ptr1, adr_ptr2);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_twiddle;
    test_saturation;
    test_back_to_back;
    test_gap_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
